// File: rtl/data_mem_pkg.sv
// Shared types and default parameters for the handshaked data-memory block.
package data_mem_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_WAIT_STATES = 0;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/data_ram_array.sv
// Single-port storage array: synchronous write, registered read, no reset on contents.
module data_ram_array
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Write-then-read on one port; read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked data memory: clear sequencer after reset, optional wait states,
// one-cycle response pulse per accepted load or store.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_CLEAR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LP_PTR_ONE    = (ADDR_WIDTH+1)'(1);
  localparam bit                  LP_HAS_WAIT   = (WAIT_STATES > 0);
  localparam logic [3:0]          LP_WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_clear_ptr;
  logic [3:0]            r_wait_cnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_busy;

  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // Reset gates the write so an aborted store or clear never lands in the array.
  assign w_ram_we    = !rst && ((r_state == ST_CLEAR) || ((r_state == ST_ACCESS) && r_write));
  assign w_ram_wdata = (r_state == ST_CLEAR) ? '0 : r_wdata;

  // In IDLE the live request address is presented so the read is ready by ACCESS.
  always_comb begin
    w_ram_addr = r_addr;
    case (r_state)
      ST_CLEAR: w_ram_addr = r_clear_ptr[ADDR_WIDTH-1:0];
      ST_IDLE:  w_ram_addr = req_addr;
      default:  w_ram_addr = r_addr;
    endcase
  end

  data_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_CLEAR;
      r_clear_ptr  <= '0;
      r_wait_cnt   <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_busy       <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clear_ptr <= r_clear_ptr + LP_PTR_ONE;
          if (r_clear_ptr == LP_CLEAR_LAST) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (LP_HAS_WAIT) begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= LP_WAIT_LOAD;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= ST_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_ACCESS: begin
          r_resp_rdata <= r_write ? r_wdata : w_ram_rdata;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_CLEAR;
          r_clear_ptr  <= '0;
          r_req_ready  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign busy       = r_busy;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: three configurations share one stimulus bus; a negedge monitor
// pops expected responses and checks data, latency and req_ready while in flight.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic [2:0]  vld = 3'b000;
  wire  [2:0]  rdy, rsp_v, bsy;
  wire  [7:0]  rd0, rd1;
  wire  [15:0] rd2;
  logic [15:0] rd [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] data;
    int          acc;
  } exp_t;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd[0] = {8'h00, rd0};
  assign rd[1] = {8'h00, rd1};
  assign rd[2] = rd2;

  data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .resp_valid(rsp_v[0]),
    .resp_rdata(rd0), .busy(bsy[0]));

  data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .resp_valid(rsp_v[1]),
    .resp_rdata(rd1), .busy(bsy[1]));

  data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_write(req_write),
    .req_addr(req_addr[3:0]), .req_wdata(req_wdata), .resp_valid(rsp_v[2]),
    .resp_rdata(rd2), .busy(bsy[2]));

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic int depth(input int k);
    return (k == 2) ? 16 : 256;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rsp_v[k] === 1'b1) begin
        if (qsize(k) == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp_dut%0d: got resp_valid=1 required no response", k);
        end else begin
          qpop(k, e);
          check($sformatf("rdata_dut%0d", k), 32'(rd[k]), 32'(e.data));
          check($sformatf("latency_dut%0d", k), 32'(cyc - e.acc), 32'(ws(k) + 1));
        end
      end else if (qsize(k) > 0) begin
        check($sformatf("ready_in_flight_dut%0d", k), 32'(rdy[k]), 32'd0);
      end
    end
  end

  // Drive one request from a negedge; returns at the negedge after acceptance.
  task automatic issue(input int k, input bit wr, input logic [7:0] a, input logic [15:0] d,
                       input logic [15:0] expv, input bit hold, output int acc);
    int   n;
    exp_t e;
    n = 0;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    vld[k]    = 1'b1;
    while (rdy[k] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (rdy[k] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout_dut%0d: req_ready=%b required 1", k, rdy[k]);
      vld[k] = 1'b0;
      acc = -1;
      return;
    end
    acc    = cyc + 1;
    e.data = expv;
    e.acc  = acc;
    @(posedge clk);
    qpush(k, e);
    @(negedge clk);
    if (!hold) vld[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qsize(0) + qsize(1) + qsize(2)) > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);
  endtask

  task automatic do_reset();
    int len [3];
    @(negedge clk);
    rst = 1'b1;
    vld = 3'b000;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready_dut%0d", k), 32'(rdy[k]), 32'd0);
      check($sformatf("rst_resp_valid_dut%0d", k), 32'(rsp_v[k]), 32'd0);
      check($sformatf("rst_busy_dut%0d", k), 32'(bsy[k]), 32'd1);
      check($sformatf("rst_rdata_dut%0d", k), 32'(rd[k]), 32'd0);
    end
    rst = 1'b0;
    len = '{-1, -1, -1};
    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < 3; k++) begin
        if (len[k] < 0 && bsy[k] === 1'b0) begin
          len[k] = t;
          check($sformatf("ready_after_clear_dut%0d", k), 32'(rdy[k]), 32'd1);
        end
      end
      if (len[0] >= 0 && len[1] >= 0 && len[2] >= 0) break;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("clear_cycles_dut%0d", k), 32'(len[k]), 32'(depth(k)));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int prev;
    int n;

    do_reset();

    for (int a = 0; a < 256; a++) issue(0, 1'b0, 8'(a), 16'h0000, 16'h0000, 1'b0, acc);
    for (int a = 0; a < 16; a++) issue(2, 1'b0, 8'(a), 16'h0000, 16'h0000, 1'b0, acc);
    drain();

    issue(0, 1'b1, 8'h10, 16'h00A5, 16'h00A5, 1'b0, acc);
    issue(0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 1'b0, acc);
    issue(0, 1'b1, 8'h11, 16'h005A, 16'h005A, 1'b0, acc);
    issue(0, 1'b0, 8'h10, 16'h0000, 16'h00A5, 1'b0, acc);
    issue(0, 1'b0, 8'h11, 16'h0000, 16'h005A, 1'b0, acc);
    drain();

    issue(1, 1'b1, 8'hFF, 16'h003C, 16'h003C, 1'b0, acc);
    issue(1, 1'b0, 8'hFF, 16'h0000, 16'h003C, 1'b0, acc);
    issue(1, 1'b1, 8'h01, 16'h0011, 16'h0011, 1'b0, acc);
    issue(1, 1'b1, 8'h02, 16'h0022, 16'h0022, 1'b0, acc);
    drain();

    prev = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b0, (i % 2 == 1) ? 8'h02 : 8'h01, 16'h0000,
            (i % 2 == 1) ? 16'h0022 : 16'h0011, 1'b1, acc);
      if (i > 0) check("stream_spacing", 32'(acc - prev), 32'd6);
      prev = acc;
    end
    vld[1] = 1'b0;
    drain();

    issue(2, 1'b1, 8'h0F, 16'hBEEF, 16'hBEEF, 1'b0, acc);
    issue(2, 1'b0, 8'h0F, 16'h0000, 16'hBEEF, 1'b0, acc);
    issue(2, 1'b1, 8'h00, 16'h1234, 16'h1234, 1'b0, acc);
    issue(2, 1'b0, 8'h00, 16'h0000, 16'h1234, 1'b0, acc);
    issue(2, 1'b0, 8'h0F, 16'h0000, 16'hBEEF, 1'b0, acc);
    drain();

    // Store accepted on dut1, then reset while it sits in WAIT: no response expected.
    req_write = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 16'h0077;
    vld[1]    = 1'b1;
    n = 0;
    while (rdy[1] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_setup_ready", 32'(rdy[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    vld[1] = 1'b0;
    check("ready_in_wait", 32'(rdy[1]), 32'd0);
    do_reset();
    issue(1, 1'b0, 8'h20, 16'h0000, 16'h0000, 1'b0, acc);
    issue(0, 1'b0, 8'h10, 16'h0000, 16'h0000, 1'b0, acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
